// File: rtl/purse_controller.sv
`default_nettype none
// ============================================================================
//  Module      : purse_controller
//  Description : Battle-game wallet. Accrues periodic income, adds enemy
//                bounties, caps money at the level-dependent maximum and
//                arbitrates deploy spends and purse upgrades. Every request
//                receives a registered ack one cycle later.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                start, stop, en   - battle control (start wins over stop)
//                spend_req/amt     - deploy request and cost
//                upgrade_req       - purse upgrade request
//                bounty_valid/amt  - enemy-kill reward
//                spend_ack/ok      - deploy response (1 cycle after req)
//                upgrade_ack/ok    - upgrade response (1 cycle after req)
//                money, level      - current balance and purse level
//                max_money         - cap for current level
//                upgrade_cost      - cost to leave current level
//                can_upgrade       - level<7 && money>=upgrade_cost
//                running           - 1 while in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module purse_controller #(
    parameter int MONEY_W     = 14,
    parameter int TICK_DIV    = 10_000_000,
    parameter int INCOME_BASE = 4,
    parameter int INCOME_STEP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               en,
    input  logic               spend_req,
    input  logic [MONEY_W-1:0] spend_amt,
    input  logic               upgrade_req,
    input  logic               bounty_valid,
    input  logic [MONEY_W-1:0] bounty_amt,
    output logic               spend_ack,
    output logic               spend_ok,
    output logic               upgrade_ack,
    output logic               upgrade_ok,
    output logic [MONEY_W-1:0] money,
    output logic [2:0]         level,
    output logic [MONEY_W-1:0] max_money,
    output logic [MONEY_W-1:0] upgrade_cost,
    output logic               can_upgrade,
    output logic               running
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int EXT_W = MONEY_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0]       c_top_level = 3'd7;
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TICK_DIV - 1);

    // Per-level tables: cost to leave a level, and the money cap at a level.
    function automatic logic [MONEY_W-1:0] cost_of(input logic [2:0] lvl);
        case (lvl)
            3'd0:    cost_of = MONEY_W'(100);
            3'd1:    cost_of = MONEY_W'(200);
            3'd2:    cost_of = MONEY_W'(400);
            3'd3:    cost_of = MONEY_W'(600);
            3'd4:    cost_of = MONEY_W'(1000);
            3'd5:    cost_of = MONEY_W'(2000);
            3'd6:    cost_of = MONEY_W'(4000);
            default: cost_of = MONEY_W'(8000);
        endcase
    endfunction

    function automatic logic [MONEY_W-1:0] max_of(input logic [2:0] lvl);
        case (lvl)
            3'd0:    max_of = MONEY_W'(100);
            3'd1:    max_of = MONEY_W'(300);
            3'd2:    max_of = MONEY_W'(500);
            3'd3:    max_of = MONEY_W'(1000);
            3'd4:    max_of = MONEY_W'(2000);
            3'd5:    max_of = MONEY_W'(4000);
            3'd6:    max_of = MONEY_W'(6000);
            default: max_of = MONEY_W'(10000);
        endcase
    endfunction

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // Datapath of the RUN-state update, evaluated every cycle.
    logic               w_tick;
    logic               w_up_ok;
    logic [2:0]         w_lvl_new;
    logic [EXT_W-1:0]   w_m1;
    logic               w_sp_ok;
    logic [EXT_W-1:0]   w_m2;
    logic [EXT_W-1:0]   w_income;
    logic [EXT_W-1:0]   w_bounty;
    logic [EXT_W-1:0]   w_m3;
    logic [MONEY_W-1:0] w_cap;
    logic [MONEY_W-1:0] w_m_sat;

    // Next-state values
    logic [0:0]         w_state_n;
    logic [CNT_W-1:0]   w_cnt_n;
    logic [MONEY_W-1:0] w_money_n;
    logic [2:0]         w_level_n;
    logic               w_sp_ok_n;
    logic               w_up_ok_n;

    always_comb begin
        w_tick    = (r_cnt == c_cnt_last) && en;
        w_up_ok   = upgrade_req && (level != c_top_level) && (money >= cost_of(level));
        w_lvl_new = level + {2'b00, w_up_ok};
        w_m1      = {1'b0, money} - (w_up_ok ? {1'b0, cost_of(level)} : '0);
        // Spend is judged against the balance left after any same-cycle upgrade.
        w_sp_ok   = spend_req && ({1'b0, spend_amt} <= w_m1);
        w_m2      = w_m1 - (w_sp_ok ? {1'b0, spend_amt} : '0);
        // Income is computed from the post-upgrade level.
        w_income  = w_tick ? (EXT_W'(INCOME_BASE) + EXT_W'(INCOME_STEP) * EXT_W'(w_lvl_new))
                           : '0;
        w_bounty  = bounty_valid ? {1'b0, bounty_amt} : '0;
        w_m3      = w_m2 + w_income + w_bounty;
        w_cap     = max_of(w_lvl_new);
        w_m_sat   = (w_m3 > {1'b0, w_cap}) ? w_cap : w_m3[MONEY_W-1:0];
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_money_n = money;
        w_level_n = level;
        w_sp_ok_n = 1'b0;
        w_up_ok_n = 1'b0;
        if (start) begin
            // Start (or restart) wins over stop and over same-cycle requests.
            w_state_n = S_RUN;
            w_cnt_n   = '0;
            w_money_n = '0;
            w_level_n = 3'd0;
        end else if (r_state == S_RUN) begin
            if (stop) begin
                w_state_n = S_IDLE;
            end else begin
                if (en) begin
                    w_cnt_n = (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
                end
                w_money_n = w_m_sat;
                w_level_n = w_lvl_new;
                w_sp_ok_n = w_sp_ok;
                w_up_ok_n = w_up_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            money        <= '0;
            level        <= 3'd0;
            max_money    <= MONEY_W'(100);
            upgrade_cost <= MONEY_W'(100);
            can_upgrade  <= 1'b0;
            spend_ack    <= 1'b0;
            spend_ok     <= 1'b0;
            upgrade_ack  <= 1'b0;
            upgrade_ok   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            money        <= w_money_n;
            level        <= w_level_n;
            // Derived values are registered from next-state so they track level/money.
            max_money    <= max_of(w_level_n);
            upgrade_cost <= cost_of(w_level_n);
            can_upgrade  <= (w_level_n != c_top_level) && (w_money_n >= cost_of(w_level_n));
            // Every request is acked; ok is only ever set by the RUN update.
            spend_ack    <= spend_req;
            spend_ok     <= w_sp_ok_n;
            upgrade_ack  <= upgrade_req;
            upgrade_ok   <= w_up_ok_n;
        end
    end

    assign running = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_purse_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_purse_controller
//  Description : Directed self-checking bench for purse_controller with
//                TICK_DIV=4. Inputs change 1 time unit after the rising
//                edge; outputs are sampled at that same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_purse_controller;

    localparam int MONEY_W = 14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, stop, en;
    logic               spend_req;
    logic [MONEY_W-1:0] spend_amt;
    logic               upgrade_req;
    logic               bounty_valid;
    logic [MONEY_W-1:0] bounty_amt;
    logic               spend_ack, spend_ok, upgrade_ack, upgrade_ok;
    logic [MONEY_W-1:0] money, max_money, upgrade_cost;
    logic [2:0]         level;
    logic               can_upgrade, running;

    int checks = 0;
    int errors = 0;

    logic [MONEY_W-1:0] cost_t [8] = '{100, 200, 400, 600, 1000, 2000, 4000, 8000};
    logic [MONEY_W-1:0] max_t  [8] = '{100, 300, 500, 1000, 2000, 4000, 6000, 10000};

    purse_controller #(
        .MONEY_W    (MONEY_W),
        .TICK_DIV   (4),
        .INCOME_BASE(4),
        .INCOME_STEP(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .spend_req   (spend_req),
        .spend_amt   (spend_amt),
        .upgrade_req (upgrade_req),
        .bounty_valid(bounty_valid),
        .bounty_amt  (bounty_amt),
        .spend_ack   (spend_ack),
        .spend_ok    (spend_ok),
        .upgrade_ack (upgrade_ack),
        .upgrade_ok  (upgrade_ok),
        .money       (money),
        .level       (level),
        .max_money   (max_money),
        .upgrade_cost(upgrade_cost),
        .can_upgrade (can_upgrade),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bounty(input logic [MONEY_W-1:0] amt);
        bounty_valid = 1'b1;
        bounty_amt   = amt;
        step();
        bounty_valid = 1'b0;
        bounty_amt   = '0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_money"},    32'(money),        0);
        check({tag, "_level"},    32'(level),        0);
        check({tag, "_max"},      32'(max_money),    100);
        check({tag, "_cost"},     32'(upgrade_cost), 100);
        check({tag, "_canup"},    32'(can_upgrade),  0);
        check({tag, "_running"},  32'(running),      0);
        check({tag, "_sp_ack"},   32'(spend_ack),    0);
        check({tag, "_sp_ok"},    32'(spend_ok),     0);
        check({tag, "_up_ack"},   32'(upgrade_ack),  0);
        check({tag, "_up_ok"},    32'(upgrade_ok),   0);
    endtask

    initial begin
        int exp_m;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
        spend_req = 1'b0; spend_amt = '0; upgrade_req = 1'b0;
        bounty_valid = 1'b0; bounty_amt = '0;
        step(); step();
        chk_reset("reset");

        // Income accrual: 4 per tick, tick every 4th cycle, cap 100 at level 0.
        rst_n = 1'b1; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        check("start_running", 32'(running), 1);
        check("start_money",   32'(money),   0);
        for (int n = 1; n <= 108; n++) begin
            step();
            exp_m = (n / 4) * 4;
            if (exp_m > 100) exp_m = 100;
            check($sformatf("income_n%0d", n), 32'(money), 32'(exp_m));
        end
        check("income_canup", 32'(can_upgrade), 1);
        en = 1'b0;

        // Upgrade from level 0 with exactly the cost.
        upgrade_req = 1'b1;
        step();
        upgrade_req = 1'b0;
        check("up1_ack",   32'(upgrade_ack),  1);
        check("up1_ok",    32'(upgrade_ok),   1);
        check("up1_money", 32'(money),        0);
        check("up1_level", 32'(level),        1);
        check("up1_max",   32'(max_money),    300);
        check("up1_cost",  32'(upgrade_cost), 200);
        check("up1_canup", 32'(can_upgrade),  0);
        step();
        check("up1_ack_drop", 32'(upgrade_ack), 0);

        // Spend denied, then exact spend, then zero spend (back-to-back acks).
        bounty(50);
        check("b50_money", 32'(money), 50);
        spend_req = 1'b1; spend_amt = 60;
        step();
        check("sp60_ack",   32'(spend_ack), 1);
        check("sp60_ok",    32'(spend_ok),  0);
        check("sp60_money", 32'(money),     50);
        spend_amt = 50;
        step();
        check("sp50_ack",   32'(spend_ack), 1);
        check("sp50_ok",    32'(spend_ok),  1);
        check("sp50_money", 32'(money),     0);
        spend_amt = 0;
        step();
        check("sp0_ack",   32'(spend_ack), 1);
        check("sp0_ok",    32'(spend_ok),  1);
        check("sp0_money", 32'(money),     0);
        spend_req = 1'b0;
        step();
        check("sp_ack_drop", 32'(spend_ack), 0);

        // Restart; upgrade has priority over a same-cycle spend.
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_level", 32'(level),     0);
        check("rs_money", 32'(money),     0);
        check("rs_max",   32'(max_money), 100);
        bounty(100);
        check("b100_money", 32'(money),       100);
        check("b100_canup", 32'(can_upgrade), 1);
        upgrade_req = 1'b1; spend_req = 1'b1; spend_amt = 10;
        step();
        upgrade_req = 1'b0; spend_req = 1'b0;
        check("prio_up_ok", 32'(upgrade_ok), 1);
        check("prio_sp_ack", 32'(spend_ack), 1);
        check("prio_sp_ok", 32'(spend_ok),   0);
        check("prio_money", 32'(money),      0);
        check("prio_level", 32'(level),      1);

        // Bounty on a tick cycle saturates: 95 + 4 + 20 -> 100.
        start = 1'b1;
        step();
        start = 1'b0;
        bounty(95);
        check("b95_money", 32'(money), 95);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("pretick_%0d", k), 32'(money), 95);
        end
        bounty(20);
        check("tick_sat_money", 32'(money), 100);
        en = 1'b0;

        // Climb to level 7.
        for (int l = 0; l < 7; l++) begin
            bounty(cost_t[l]);
            check($sformatf("climb%0d_money", l), 32'(money), 32'(cost_t[l]));
            upgrade_req = 1'b1;
            step();
            upgrade_req = 1'b0;
            check($sformatf("climb%0d_ok", l),    32'(upgrade_ok),   1);
            check($sformatf("climb%0d_level", l), 32'(level),        32'(l + 1));
            check($sformatf("climb%0d_money0", l), 32'(money),       0);
            check($sformatf("climb%0d_max", l),   32'(max_money),    32'(max_t[l + 1]));
            check($sformatf("climb%0d_cost", l),  32'(upgrade_cost), 32'(cost_t[l + 1]));
        end
        bounty(9000);
        check("l7_money", 32'(money),       9000);
        check("l7_canup", 32'(can_upgrade), 0);
        upgrade_req = 1'b1;
        step();
        upgrade_req = 1'b0;
        check("l7_up_ack", 32'(upgrade_ack), 1);
        check("l7_up_ok",  32'(upgrade_ok),  0);
        check("l7_level",  32'(level),       7);
        check("l7_money2", 32'(money),       9000);
        bounty(16383);
        check("l7_sat", 32'(money), 10000);

        // Paused: income frozen, spends still served.
        repeat (20) step();
        check("pause_money", 32'(money), 10000);
        spend_req = 1'b1; spend_amt = 500;
        step();
        spend_req = 1'b0;
        check("pause_sp_ok",  32'(spend_ok), 1);
        check("pause_money2", 32'(money),    9500);

        // Stop: IDLE holds values, acks with ok=0, ignores bounty.
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_running", 32'(running), 0);
        check("stop_money",   32'(money),   9500);
        check("stop_level",   32'(level),   7);
        spend_req = 1'b1; spend_amt = 0;
        step();
        spend_req = 1'b0;
        check("idle_sp_ack", 32'(spend_ack), 1);
        check("idle_sp_ok",  32'(spend_ok),  0);
        bounty(10);
        check("idle_bounty", 32'(money), 9500);

        // Async reset mid-RUN with a request pending.
        start = 1'b1; en = 1'b1;
        step();
        start = 1'b0;
        check("rs2_running", 32'(running), 1);
        bounty(30);
        check("rs2_money", 32'(money), 30);
        spend_req = 1'b1; spend_amt = 5;
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        step();
        check("rst_ack_dropped", 32'(spend_ack), 0);
        spend_req = 1'b0;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
